// File: rtl/lstm_delta_seq_pkg.sv
// Shared types and constants for the LSTM backprop delta engine.
// Holds FSM encoding, step counts and per-cell input/gate indices.
package lstm_delta_seq_pkg;
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAL,
    ST_MAC,
    ST_DONE
  } state_e;

  localparam int SCAL_STEPS = 16;
  localparam int NSCAL = 11;

  localparam int S_T   = 0;
  localparam int S_H   = 1;
  localparam int S_DHP = 2;
  localparam int S_DCP = 3;
  localparam int S_CN  = 4;
  localparam int S_C   = 5;
  localparam int S_A   = 6;
  localparam int S_I   = 7;
  localparam int S_F   = 8;
  localparam int S_O   = 9;
  localparam int S_FP  = 10;

  localparam int G_A = 0;
  localparam int G_I = 1;
  localparam int G_F = 2;
  localparam int G_O = 3;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lstm_delta_seq_if.sv
// Start/done handshake bundle of the delta engine.
// The engine is the slave; the sequencer driving it is the master.
interface lstm_delta_seq_if;
  logic i_start;
  logic o_ready;
  logic o_busy;
  logic o_done;

  modport master (
    output i_start,
    input  o_ready,
    input  o_busy,
    input  o_done
  );

  modport slave (
    input  i_start,
    output o_ready,
    output o_busy,
    output o_done
  );
endinterface

// File: rtl/lstm_delta_seq_mult.sv
// Shared fixed-point multiplier (wrap or saturate) and the
// clamp-style tanh used for the cell-state activation.
module fxp_mult_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24,
  parameter int SAT   = 0
) (
  input  logic signed [WIDTH-1:0] a,
  input  logic signed [WIDTH-1:0] b,
  output logic signed [WIDTH-1:0] p
);
  localparam int PW = 2 * WIDTH;
  localparam logic signed [PW-1:0] MAXV =
    {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0] MINV =
    {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic signed [PW-1:0] full;
  logic signed [PW-1:0] shf;

  assign full = {{WIDTH{a[WIDTH-1]}}, a}
              * {{WIDTH{b[WIDTH-1]}}, b};
  assign shf = full >>> FRAC;

  always_comb begin
    p = shf[WIDTH-1:0];
    if (SAT != 0) begin
      if (shf > MAXV) p = MAXV[WIDTH-1:0];
      else if (shf < MINV) p = MINV[WIDTH-1:0];
    end
  end
endmodule

module lstm_tanh #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] x,
  output logic signed [WIDTH-1:0] y
);
  localparam logic signed [WIDTH-1:0] ONE =
    {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;
  localparam logic signed [WIDTH-1:0] NEG = -ONE;

  always_comb begin
    y = x;
    if (x > ONE) y = ONE;
    else if (x < NEG) y = NEG;
  end
endmodule

// File: rtl/lstm_delta_seq.sv
// LSTM BPTT delta engine: per-cell scalar chain then weight MACs,
// all products time-multiplexed onto one fixed-point multiplier.
module lstm_delta_seq
  import lstm_delta_seq_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 24,
  parameter int NUM      = 2,
  parameter int NUM_LSTM = 1,
  parameter int SAT      = 0
) (
  input  logic clk,
  input  logic rst,
  lstm_delta_seq_if.slave hs,
  input  logic [NUM_LSTM*WIDTH-1:0] i_t,
  input  logic [NUM_LSTM*WIDTH-1:0] i_h,
  input  logic [NUM_LSTM*WIDTH-1:0] i_d_h_prev,
  input  logic [NUM_LSTM*WIDTH-1:0] i_d_c_prev,
  input  logic [NUM_LSTM*WIDTH-1:0] i_c_next,
  input  logic [NUM_LSTM*WIDTH-1:0] i_c,
  input  logic [NUM_LSTM*WIDTH-1:0] i_a,
  input  logic [NUM_LSTM*WIDTH-1:0] i_i,
  input  logic [NUM_LSTM*WIDTH-1:0] i_f,
  input  logic [NUM_LSTM*WIDTH-1:0] i_o,
  input  logic [NUM_LSTM*WIDTH-1:0] i_f_prev,
  input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] w_a,
  input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] w_i,
  input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] w_f,
  input  logic [NUM_LSTM*(NUM+NUM_LSTM)*WIDTH-1:0] w_o,
  output logic [NUM_LSTM*WIDTH-1:0] o_d_tot,
  output logic [NUM_LSTM*WIDTH-1:0] o_d_c_next,
  output logic [NUM_LSTM*4*WIDTH-1:0] o_dgates,
  output logic [NUM*WIDTH-1:0] o_d_x_now,
  output logic [NUM_LSTM*WIDTH-1:0] o_d_h_next
);
  localparam int ROW   = NUM + NUM_LSTM;
  localparam int MACN  = 4 * ROW;
  localparam int NSTEP = (MACN > SCAL_STEPS) ? MACN : SCAL_STEPS;
  localparam int SW    = clog2_min1(NSTEP);
  localparam int CW    = clog2_min1(NUM_LSTM);
  localparam int JW    = clog2_min1(ROW);
  localparam int NC    = 1 << CW;
  localparam int NJ    = 1 << JW;
  localparam int WROW  = NUM_LSTM * ROW * WIDTH;

  typedef logic signed [WIDTH-1:0] word_t;
  localparam word_t ONE = {{(WIDTH-1){1'b0}}, 1'b1} << FRAC;

  // Arrays are padded to powers of two so counter indices fit exactly.
  logic [NUM_LSTM*WIDTH-1:0] sin [NSCAL];
  logic [WROW-1:0] win [4];
  word_t sc [NSCAL][NC];
  word_t wt [4][NC][NJ];

  assign sin[S_T]   = i_t;
  assign sin[S_H]   = i_h;
  assign sin[S_DHP] = i_d_h_prev;
  assign sin[S_DCP] = i_d_c_prev;
  assign sin[S_CN]  = i_c_next;
  assign sin[S_C]   = i_c;
  assign sin[S_A]   = i_a;
  assign sin[S_I]   = i_i;
  assign sin[S_F]   = i_f;
  assign sin[S_O]   = i_o;
  assign sin[S_FP]  = i_f_prev;
  assign win[G_A] = w_a;
  assign win[G_I] = w_i;
  assign win[G_F] = w_f;
  assign win[G_O] = w_o;

  for (genvar k = 0; k < NC; k++) begin : g_c
    for (genvar s = 0; s < NSCAL; s++) begin : g_s
      if (k < NUM_LSTM) begin : g_v
        assign sc[s][k] = sin[s][k*WIDTH +: WIDTH];
      end else begin : g_z
        assign sc[s][k] = '0;
      end
    end
    for (genvar g = 0; g < 4; g++) begin : g_g
      for (genvar j = 0; j < NJ; j++) begin : g_j
        if (k < NUM_LSTM && j < ROW) begin : g_v
          assign wt[g][k][j] =
            win[g][(k*ROW+j)*WIDTH +: WIDTH];
        end else begin : g_z
          assign wt[g][k][j] = '0;
        end
      end
    end
  end

  state_e state_q, state_d;
  logic [SW-1:0] step_q, step_d;
  logic [CW-1:0] cell_q, cell_d;
  word_t s_q, s_d, q_q, q_d, dcn_q, dcn_d;
  word_t dg_q [4];
  word_t dg_d [4];
  word_t acc_q [NJ];
  word_t acc_d [NJ];
  word_t sum_q [NJ];
  word_t sum_d [NJ];
  word_t tot_q [NC];
  word_t tot_d [NC];
  word_t dco_q [NC];
  word_t dco_d [NC];
  word_t dgo_q [NC][4];
  word_t dgo_d [NC][4];

  word_t ma, mb, prod, tc, d_tot, d_h;
  logic [JW-1:0] j_idx;
  logic [1:0] g_idx;
  int st;

  fxp_mult_sat #(.WIDTH(WIDTH), .FRAC(FRAC), .SAT(SAT)) u_mul (
    .a(ma), .b(mb), .p(prod)
  );

  lstm_tanh #(.WIDTH(WIDTH), .FRAC(FRAC)) u_tanh (
    .x(sc[S_C][cell_q]), .y(tc)
  );

  assign st    = int'(step_q);
  assign j_idx = JW'(step_q >> 2);
  assign g_idx = step_q[1:0];
  assign d_tot = sc[S_H][cell_q] - sc[S_T][cell_q];
  assign d_h   = d_tot + sc[S_DHP][cell_q];

  assign hs.o_ready = (state_q == ST_IDLE);
  assign hs.o_busy  = (state_q == ST_SCAL) || (state_q == ST_MAC);
  assign hs.o_done  = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    cell_d  = cell_q;
    s_d     = s_q;
    q_d     = q_q;
    dcn_d   = dcn_q;
    dg_d    = dg_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    tot_d   = tot_q;
    dco_d   = dco_q;
    dgo_d   = dgo_q;
    ma      = '0;
    mb      = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (hs.i_start) begin
          state_d = ST_SCAL;
          step_d  = '0;
          cell_d  = '0;
          acc_d   = '{default: '0};
        end
      end
      ST_SCAL: begin
        step_d = step_q + SW'(1);
        case (st)
          0:  begin ma = d_h; mb = sc[S_O][cell_q]; s_d = prod; end
          1:  begin ma = tc; mb = tc; q_d = prod; end
          2:  begin ma = s_q; mb = ONE - q_q; s_d = prod; end
          3:  begin
            ma = sc[S_FP][cell_q];
            mb = sc[S_DCP][cell_q];
            dcn_d = s_q + prod;
          end
          4:  begin ma = dcn_q; mb = sc[S_I][cell_q]; s_d = prod; end
          5:  begin ma = sc[S_A][cell_q]; mb = sc[S_A][cell_q]; q_d = prod; end
          6:  begin ma = s_q; mb = ONE - q_q; dg_d[G_A] = prod; end
          7:  begin ma = dcn_q; mb = sc[S_A][cell_q]; s_d = prod; end
          8:  begin ma = s_q; mb = sc[S_I][cell_q]; s_d = prod; end
          9:  begin ma = s_q; mb = ONE - sc[S_I][cell_q]; dg_d[G_I] = prod; end
          10: begin ma = dcn_q; mb = sc[S_CN][cell_q]; s_d = prod; end
          11: begin ma = s_q; mb = sc[S_F][cell_q]; s_d = prod; end
          12: begin ma = s_q; mb = ONE - sc[S_F][cell_q]; dg_d[G_F] = prod; end
          13: begin ma = d_h; mb = tc; s_d = prod; end
          14: begin ma = s_q; mb = sc[S_O][cell_q]; s_d = prod; end
          default: begin
            ma = s_q;
            mb = ONE - sc[S_O][cell_q];
            dg_d[G_O] = prod;
            tot_d[cell_q] = d_tot;
            dco_d[cell_q] = dcn_q;
            dgo_d[cell_q][G_A] = dg_q[G_A];
            dgo_d[cell_q][G_I] = dg_q[G_I];
            dgo_d[cell_q][G_F] = dg_q[G_F];
            dgo_d[cell_q][G_O] = prod;
            step_d  = '0;
            state_d = ST_MAC;
          end
        endcase
      end
      ST_MAC: begin
        ma = dg_q[g_idx];
        mb = wt[g_idx][cell_q][j_idx];
        acc_d[j_idx] = acc_q[j_idx] + prod;
        step_d = step_q + SW'(1);
        if (st == MACN - 1) begin
          step_d = '0;
          if (int'(cell_q) == NUM_LSTM - 1) begin
            sum_d   = acc_d;
            state_d = ST_DONE;
          end else begin
            cell_d  = cell_q + CW'(1);
            state_d = ST_SCAL;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      cell_q  <= '0;
      s_q     <= '0;
      q_q     <= '0;
      dcn_q   <= '0;
      dg_q    <= '{default: '0};
      acc_q   <= '{default: '0};
      sum_q   <= '{default: '0};
      tot_q   <= '{default: '0};
      dco_q   <= '{default: '0};
      dgo_q   <= '{default: '0};
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      cell_q  <= cell_d;
      s_q     <= s_d;
      q_q     <= q_d;
      dcn_q   <= dcn_d;
      dg_q    <= dg_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      tot_q   <= tot_d;
      dco_q   <= dco_d;
      dgo_q   <= dgo_d;
    end
  end

  for (genvar k = 0; k < NUM_LSTM; k++) begin : g_ok
    assign o_d_tot[k*WIDTH +: WIDTH]    = tot_q[k];
    assign o_d_c_next[k*WIDTH +: WIDTH] = dco_q[k];
    assign o_d_h_next[k*WIDTH +: WIDTH] = sum_q[NUM+k];
    for (genvar g = 0; g < 4; g++) begin : g_og
      assign o_dgates[(k*4+g)*WIDTH +: WIDTH] = dgo_q[k][g];
    end
  end

  for (genvar j = 0; j < NUM; j++) begin : g_ox
    assign o_d_x_now[j*WIDTH +: WIDTH] = sum_q[j];
  end
endmodule

// File: tb/tb_lstm_delta_seq.sv
// Directed bench for lstm_delta_seq: defaults, SAT=1 and
// NUM_LSTM=2 instances share clock, reset and start.
module tb_lstm_delta_seq;
  localparam int W = 32;
  localparam logic [W-1:0] ONE = 32'h01000000;

  logic clk = 1'b0;
  logic rst;
  logic start;
  int vecs = 0;
  int errs = 0;
  int dcyc0, dcyc2, bcnt0, nd0, nd2, nq;

  always #5 clk = ~clk;

  lstm_delta_seq_if hs0();
  lstm_delta_seq_if hs1();
  lstm_delta_seq_if hs2();
  assign hs0.i_start = start;
  assign hs1.i_start = start;
  assign hs2.i_start = start;

  logic [W-1:0] t, h, dhp, dcp, cn, c, a, i, f, o, fp;
  logic [3*W-1:0] wa, wi, wf, wo;
  logic [8*W-1:0] wa2;

  logic [W-1:0] tot0, dcn0, hn0, tot1, dcn1, hn1;
  logic [4*W-1:0] dg0, dg1;
  logic [2*W-1:0] x0, x1;
  logic [2*W-1:0] tot2, dcn2, hn2, x2;
  logic [8*W-1:0] dg2;

  lstm_delta_seq dut0 (
    .clk(clk), .rst(rst), .hs(hs0),
    .i_t(t), .i_h(h), .i_d_h_prev(dhp), .i_d_c_prev(dcp),
    .i_c_next(cn), .i_c(c), .i_a(a), .i_i(i), .i_f(f),
    .i_o(o), .i_f_prev(fp),
    .w_a(wa), .w_i(wi), .w_f(wf), .w_o(wo),
    .o_d_tot(tot0), .o_d_c_next(dcn0), .o_dgates(dg0),
    .o_d_x_now(x0), .o_d_h_next(hn0)
  );

  lstm_delta_seq #(.SAT(1)) dut1 (
    .clk(clk), .rst(rst), .hs(hs1),
    .i_t(t), .i_h(h), .i_d_h_prev(dhp), .i_d_c_prev(dcp),
    .i_c_next(cn), .i_c(c), .i_a(a), .i_i(i), .i_f(f),
    .i_o(o), .i_f_prev(fp),
    .w_a(wa), .w_i(wi), .w_f(wf), .w_o(wo),
    .o_d_tot(tot1), .o_d_c_next(dcn1), .o_dgates(dg1),
    .o_d_x_now(x1), .o_d_h_next(hn1)
  );

  lstm_delta_seq #(.NUM_LSTM(2)) dut2 (
    .clk(clk), .rst(rst), .hs(hs2),
    .i_t({t, t}), .i_h({h, h}), .i_d_h_prev({dhp, dhp}),
    .i_d_c_prev({dcp, dcp}), .i_c_next({cn, cn}), .i_c({c, c}),
    .i_a({a, a}), .i_i({i, i}), .i_f({f, f}), .i_o({o, o}),
    .i_f_prev({fp, fp}),
    .w_a(wa2), .w_i('0), .w_f('0), .w_o('0),
    .o_d_tot(tot2), .o_d_c_next(dcn2), .o_dgates(dg2),
    .o_d_x_now(x2), .o_d_h_next(hn2)
  );

  task automatic chk(input string tag, input logic [255:0] obs,
                     input logic [255:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic zero_in();
    {t, h, dhp, dcp, cn, c, a, i, f, o, fp} = '0;
    {wa, wi, wf, wo} = '0;
    wa2 = '0;
  endtask

  task automatic run(input int p1, input int p2);
    dcyc0 = -1; dcyc2 = -1; bcnt0 = 0; nd0 = 0; nd2 = 0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (n > 0) begin @(posedge clk); #1; end
      if (hs0.o_busy) bcnt0++;
      if (hs0.o_done) begin nd0++; if (dcyc0 < 0) dcyc0 = n; end
      if (hs2.o_done) begin nd2++; if (dcyc2 < 0) dcyc2 = n; end
      start = (n + 1 == p1) || (n + 1 == p2);
    end
    start = 1'b0;
  endtask

  task automatic load_v5();
    zero_in();
    h = ONE; t = 32'h00400000; dhp = 32'h00400000;
    o = 32'h00800000; fp = 32'h00800000; dcp = 32'h00800000;
    a = 32'h00800000; i = 32'h00800000; f = 32'h00800000;
    cn = ONE;
    wa = {ONE, ONE, ONE};
    wi = {32'h0, 32'h0, 32'h02000000};
    wf = {32'h0, 32'hFF000000, 32'h0};
  endtask

  task automatic chk_v5(input string pfx);
    chk({pfx, "_dtot"}, 256'(tot0), 256'h00C00000);
    chk({pfx, "_dcn"}, 256'(dcn0), 256'h00C00000);
    chk({pfx, "_dgates"}, 256'(dg0),
        256'h00000000_00300000_00180000_00480000);
    chk({pfx, "_dx"}, 256'(x0), 256'h00180000_00780000);
    chk({pfx, "_dh"}, 256'(hn0), 256'h00480000);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    zero_in();
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(hs0.o_ready), 256'd1);
    chk("rst_busy", 256'(hs0.o_busy), 256'd0);
    chk("rst_done", 256'(hs0.o_done), 256'd0);
    chk("rst_data", 256'({tot0, dcn0, dg0, x0, hn0}), 256'd0);
    chk("rst_data2", 256'({dcn2, x2, hn2}), 256'd0);
    rst = 1'b0;

    run(-1, -1);
    chk("zero_done_cyc", 256'(dcyc0), 256'd28);
    chk("zero_busy_cnt", 256'(bcnt0), 256'd28);
    chk("zero_done_cnt", 256'(nd0), 256'd1);
    chk("zero_data", 256'({tot0, dcn0, dg0, x0, hn0}), 256'd0);
    chk("zero_ready", 256'(hs0.o_ready), 256'd1);

    zero_in();
    h = ONE; o = ONE; i = 32'h00800000;
    wa = {ONE, ONE, ONE};
    wa2 = {8{ONE}};
    run(-1, -1);
    chk("v2_dtot", 256'(tot0), 256'h01000000);
    chk("v2_dcn", 256'(dcn0), 256'h01000000);
    chk("v2_dgates", 256'(dg0), 256'h00800000);
    chk("v2_dx", 256'(x0), 256'h00800000_00800000);
    chk("v2_dh", 256'(hn0), 256'h00800000);
    chk("v2_sat_dcn", 256'(dcn1), 256'h01000000);
    chk("n2_done_cyc", 256'(dcyc2), 256'd64);
    chk("n2_done_cnt", 256'(nd2), 256'd1);
    chk("n2_dcn", 256'(dcn2), 256'h01000000_01000000);
    chk("n2_dx", 256'(x2), 256'h01000000_01000000);
    chk("n2_dh", 256'(hn2), 256'h01000000_01000000);

    zero_in();
    h = 32'h40000000; o = 32'h04000000;
    run(-1, -1);
    chk("ovf_dtot", 256'(tot0), 256'h40000000);
    chk("ovf_wrap_dcn", 256'(dcn0), 256'h00000000);
    chk("ovf_sat_dcn", 256'(dcn1), 256'h7FFFFFFF);

    load_v5();
    run(-1, -1);
    chk_v5("v5");

    run(5, 29);
    chk("spur_done_cnt", 256'(nd0), 256'd1);
    chk("spur_done_cyc", 256'(dcyc0), 256'd28);
    chk_v5("spur");

    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_data", 256'({tot0, dcn0, dg0, x0, hn0}), 256'd0);
    chk("abort_ready", 256'(hs0.o_ready), 256'd1);
    chk("abort_busy", 256'(hs0.o_busy), 256'd0);
    @(negedge clk); rst = 1'b0;
    nq = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (hs0.o_done) nq++;
    end
    chk("abort_no_done", 256'(nq), 256'd0);
    run(-1, -1);
    chk("rerun_done_cyc", 256'(dcyc0), 256'd28);
    chk_v5("rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
